// File: rtl/flag_frame_pkg.sv
// Shared types and constants for the flag-delimited serial transmitter.
package flag_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLAG  = 3'd1,
    ST_DATA  = 3'd2,
    ST_STUFF = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [6:0] FLAG_PATTERN = 7'b0111110;
  localparam int         FLAG_LEN     = 7;
  localparam int         STUFF_RUN    = 4;

  // Flag bit number idx, sent MSB-first (idx 0 is the leading zero).
  function automatic logic flag_bit(input logic [2:0] idx);
    return FLAG_PATTERN[3'd6 - idx];
  endfunction

endpackage

// File: rtl/zero_stuffer.sv
// Counts consecutive payload ones and requests a stuffed zero after a run of STUFF_RUN.
module zero_stuffer
  import flag_frame_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_valid,
  input  logic bit_in,
  output logic stuff_req
);

  logic [2:0] ones_run;

  // The request fires on the bit that completes the run, so the zero follows it directly.
  assign stuff_req = bit_valid & bit_in & (ones_run == 3'(STUFF_RUN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_run <= 3'd0;
    end else if (clr) begin
      ones_run <= 3'd0;
    end else if (bit_valid) begin
      ones_run <= bit_in ? ones_run + 3'd1 : 3'd0;
    end
  end

endmodule

// File: rtl/flag_frame_tx.sv
// Serial frame transmitter: 7-bit start flag, then payload MSB-first on j, idle-high.
// Zero-stuffing is compiled in only when FLAG_FRAME_TX_STUFF_EN is defined.
module flag_frame_tx
  import flag_frame_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int IDLE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              j,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = $clog2(IDLE_GAP + 1);

  state_t              state_reg;
  logic [2:0]          flag_idx_reg;
  logic [IDX_W-1:0]    data_idx_reg;
  logic [GAP_W-1:0]    gap_cnt_reg;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   shifted;
  logic                last_reg;
  logic                j_reg;
  logic                done_reg;
  logic                stuff_req;

  assign shifted = shreg << 1;
  assign ready   = (state_reg == ST_IDLE);
  assign busy    = (state_reg != ST_IDLE);
  assign j       = j_reg;
  assign done    = done_reg;

`ifdef FLAG_FRAME_TX_STUFF_EN
  zero_stuffer u_stuffer (
    .clk       (clk),
    .rst       (rst),
    .clr       ((state_reg == ST_FLAG) || (state_reg == ST_STUFF)),
    .bit_valid (state_reg == ST_DATA),
    .bit_in    (shreg[DATA_W-1]),
    .stuff_req (stuff_req)
  );
`else
  assign stuff_req = 1'b0;
`endif

  // j and state move together: each edge loads the bit belonging to the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      flag_idx_reg <= 3'd0;
      data_idx_reg <= '0;
      gap_cnt_reg  <= '0;
      shreg        <= '0;
      last_reg     <= 1'b0;
      j_reg        <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (valid) begin
            state_reg    <= ST_FLAG;
            flag_idx_reg <= 3'd0;
            shreg        <= data_in;
            j_reg        <= flag_bit(3'd0);
          end
        end
        ST_FLAG: begin
          if (flag_idx_reg == 3'(FLAG_LEN - 1)) begin
            state_reg    <= ST_DATA;
            data_idx_reg <= IDX_W'(DATA_W - 1);
            j_reg        <= shreg[DATA_W-1];
          end else begin
            flag_idx_reg <= flag_idx_reg + 3'd1;
            j_reg        <= flag_bit(flag_idx_reg + 3'd1);
          end
        end
        ST_DATA: begin
          shreg    <= shifted;
          last_reg <= (data_idx_reg == '0);
          if (data_idx_reg != '0) begin
            data_idx_reg <= data_idx_reg - IDX_W'(1);
          end
          if (stuff_req) begin
            state_reg <= ST_STUFF;
            j_reg     <= 1'b0;
          end else if (data_idx_reg == '0) begin
            state_reg   <= ST_GAP;
            gap_cnt_reg <= GAP_W'(IDLE_GAP - 1);
            j_reg       <= 1'b1;
            done_reg    <= 1'b1;
          end else begin
            j_reg <= shifted[DATA_W-1];
          end
        end
        ST_STUFF: begin
          // last_reg remembers whether the run ended on payload bit 0.
          if (last_reg) begin
            state_reg   <= ST_GAP;
            gap_cnt_reg <= GAP_W'(IDLE_GAP - 1);
            j_reg       <= 1'b1;
            done_reg    <= 1'b1;
          end else begin
            state_reg <= ST_DATA;
            j_reg     <= shreg[DATA_W-1];
          end
        end
        ST_GAP: begin
          j_reg <= 1'b1;
          if (gap_cnt_reg == '0) begin
            state_reg <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          j_reg     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/flag_frame_tx.md
# flag_frame_tx

Serial frame transmitter that drives the single-bit line `j` consumed by the team's flag detector. It accepts a parallel payload through a valid/ready handshake and emits the 7-bit start flag `0111110` MSB-first on `j`, followed by the payload MSB-first. With stuffing enabled, a zero is inserted after every run of four consecutive payload 1s, so a flag never appears inside the payload. It is the transmit end of the same serial link, and holds `j` high while idle.

## Interface
- `DATA_W`, default 8: payload width in bits, minimum 1.
- `IDLE_GAP`, default 2: number of cycles `j` is held high after a frame before `ready` reasserts, minimum 1.

- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `data_in`  input  DATA_W  payload; sampled only on an accepted handshake.
- `valid`  input  1  payload offered.
- `ready`  output  1  block can accept a payload; high only in IDLE.
- `j`  output  1  registered serial line, idle-high.
- `busy`  output  1  high while in any state other than IDLE.
- `done`  output  1  one-cycle pulse when the final payload bit (or final stuffed zero) has been driven.

## Operation
- FSM states: IDLE, FLAG, DATA, STUFF, GAP.
- IDLE:
  - `ready`=1 and `j`=1.
  - When `valid & ready` is high at a rising edge, `data_in` is latched into a shift register, `flag_idx` is cleared, and the FSM moves to FLAG.
- FLAG:
  - Drives flag bits 0,1,1,1,1,1,0 in order, one per cycle.
  - After bit 6, moves to DATA with `ones_run`=0.
- DATA:
  - Drives the payload MSB-first and counts down `data_idx` from DATA_W-1.
  - A driven 1 increments `ones_run`; a driven 0 clears it.
  - If the driven bit makes `ones_run` equal 4 (STUFF_EN only), the FSM goes to STUFF next.
  - Otherwise, after bit 0 the FSM goes to GAP.
- STUFF:
  - Drives 0 for one cycle and clears `ones_run`.
  - Returns to DATA if payload bits remain, else goes to GAP.
  - A stuffed zero is also inserted after a run of four 1s that ends exactly at payload bit 0.
- GAP:
  - `j`=1 for IDLE_GAP cycles, then IDLE.
  - `done` pulses in the first GAP cycle.
- `valid` while not `ready` is ignored; `data_in` changes mid-frame have no effect.
- Frame length = 7 + DATA_W + number of stuffed zeros.
- `ones_run` is 3 bits wide and never exceeds 4.

## Timing
- Reset values: `j`=1, `ready`=1, `busy`=0, `done`=0, state IDLE, all counters 0.
- Handshake accepted at edge t → the first flag bit (0) appears on `j` in cycle t+1.
- Payload bit DATA_W-1 appears in cycle t+8.
- `done` is high in the cycle after the last frame bit. `ready` is high IDLE_GAP cycles after that `done` cycle began.
- Back-to-back traffic: with `valid` held high, the next frame starts the cycle after `ready` rises. Minimum spacing between frame starts is frame length + IDLE_GAP + 1 cycles.
- Reset asserted mid-frame: all outputs return immediately (asynchronously) to reset values. The partial frame is abandoned and not resumed.
- `j` is a flop output and is never combinationally derived.

## Configuration
- `FLAG_FRAME_TX_STUFF_EN` defined: zero-stuffing after four consecutive payload 1s, as described above.
- Not defined:
  - The STUFF state and `ones_run` counter are not compiled in.
  - The payload is sent raw, and frame length is always 7 + DATA_W.
  - The caller guarantees the payload contains no flag emulation.

## Structure
- Package `flag_frame_pkg` holds:
  - the state enum;
  - `FLAG_PATTERN` = 7'b0111110;
  - `FLAG_LEN` = 7;
  - `STUFF_RUN` = 4.
- One sub-module, `zero_stuffer`: tracks `ones_run` and raises `stuff_req`. It is instantiated only under `FLAG_FRAME_TX_STUFF_EN`.
- The rest (FSM, shift register, counters, output flop) stays in `flag_frame_tx`.

## Test plan
- Reset check: hold `rst` for 3 cycles → `j`=1, `ready`=1, `busy`=0, `done`=0. Assert `rst` in the 3rd DATA cycle → `j`=1 and `ready`=1 with no clock edge needed.
- Send `data_in`=0xA5 with stuffing on → `j` = 0111110 10100101 (15 bits), then `done` for 1 cycle, `ready` 2 cycles later.
- Send 0xFF with stuffing on → payload 1111 0 1111 0, 17-bit frame, `done` after the final stuffed 0.
- Send 0x7C with stuffing on → payload 0 1111 0 1 0 0 (9 bits), 16-bit frame.
- Send 0xFF without `FLAG_FRAME_TX_STUFF_EN` → payload 11111111, 15-bit frame.
- Hold `valid`=1 with 0x3C then 0x81 → two frames, `j`=1 for exactly IDLE_GAP cycles between them. A valid offered while `busy` is ignored, and the second payload is the one presented when `ready` rises.
